// File: rtl/led_out.sv
// Memory-mapped LED output port: full/byte data writes, optional blink (LED_BLINK_EN), read-back.
// Latency: registers update on the falling edge that samples led_wen; led_rdata is combinational.
// Backpressure: none; every strobe is accepted, and repeated writes are idempotent.
module led_out #(
   parameter int BLINK_DIV = 50_000_000,
   parameter int CNT_W     = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_wen,
   input  logic [1:0]  led_addr,
   input  logic [15:0] led_wdata,
   output logic [15:0] led_rdata,
   output logic [15:0] led
);

   localparam logic [1:0] ADDR_WORD = 2'b00;
   localparam logic [1:0] ADDR_LO   = 2'b01;
   localparam logic [1:0] ADDR_HI   = 2'b10;
   localparam logic [1:0] ADDR_CTRL = 2'b11;

   logic [15:0] data;
   logic [15:0] data_next;
   logic [15:0] led_next;
   logic [15:0] status;

   always_comb begin
      data_next = data;
      if (led_wen) begin
         case (led_addr)
            ADDR_WORD: data_next = led_wdata;
            ADDR_LO:   data_next = {data[15:8], led_wdata[7:0]};
            ADDR_HI:   data_next = {led_wdata[7:0], data[7:0]};
            default:   data_next = data;
         endcase
      end
   end

`ifdef LED_BLINK_EN
   typedef enum logic {
      STEADY = 1'b0,
      BLINK  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             phase;
   logic             phase_next;
   logic             ctrl_wr;
   logic             blink_en;
   logic             blink_en_next;

   assign ctrl_wr = led_wen && (led_addr == ADDR_CTRL);

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state <= STEADY;
         cnt   <= '0;
         phase <= 1'b1;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         phase <= phase_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      phase_next = phase;
      case (state)
         STEADY: begin
            cnt_next   = '0;
            phase_next = 1'b1;
            if (ctrl_wr && led_wdata[0]) begin
               state_next = BLINK;
            end
         end
         BLINK: begin
            // A repeated enable write falls through here so the phase timing is not restarted.
            if (ctrl_wr && !led_wdata[0]) begin
               state_next = STEADY;
               cnt_next   = '0;
               phase_next = 1'b1;
            end else if (cnt == CNT_MAX) begin
               cnt_next   = '0;
               phase_next = !phase;
            end else begin
               cnt_next   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_next = STEADY;
            cnt_next   = '0;
            phase_next = 1'b1;
         end
      endcase
   end

   assign blink_en      = (state == BLINK);
   assign blink_en_next = (state_next == BLINK);
   assign led_next      = (blink_en_next && !phase_next) ? 16'h0000 : data_next;
   assign status        = {14'b0, phase, blink_en};
`else
   assign led_next = data_next;
   assign status   = 16'h0002;
`endif

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         data <= 16'h0000;
         led  <= 16'h0000;
      end else begin
         data <= data_next;
         led  <= led_next;
      end
   end

   always_comb begin
      led_rdata = 16'h0000;
      case (led_addr)
         ADDR_WORD: led_rdata = data;
         ADDR_LO:   led_rdata = {8'h00, data[7:0]};
         ADDR_HI:   led_rdata = {8'h00, data[15:8]};
         ADDR_CTRL: led_rdata = status;
         default:   led_rdata = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_led_out.sv
// Directed-vector bench for led_out with BLINK_DIV=4; blink checks follow LED_BLINK_EN.
module tb_led_out;

   logic        clk = 1'b0;
   logic        rst;
   logic        led_wen;
   logic [1:0]  led_addr;
   logic [15:0] led_wdata;
   logic [15:0] led_rdata;
   logic [15:0] led;

   int errors = 0;
   int checks = 0;

   led_out #(.BLINK_DIV(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .led_wen   (led_wen),
      .led_addr  (led_addr),
      .led_wdata (led_wdata),
      .led_rdata (led_rdata),
      .led       (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_led;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one bus cycle from just after the rising edge; return just after the sampling falling edge.
   task automatic step(input logic wen, input logic [1:0] addr, input logic [15:0] wd);
      @(posedge clk);
      #1;
      led_wen   = wen;
      led_addr  = addr;
      led_wdata = wd;
      @(negedge clk);
      #1;
      led_wen   = 1'b0;
   endtask

   task automatic rd(input logic [1:0] addr, input logic [15:0] exp, input string name);
      led_addr = addr;
      #1;
      check(name, led_rdata, exp);
   endtask

   initial begin
      vecs[0] = '{1'b1, 2'b00, 16'hA5C3, 16'hA5C3, 16'hA5C3};
      vecs[1] = '{1'b1, 2'b01, 16'hFF7E, 16'hA57E, 16'h007E};
      vecs[2] = '{1'b1, 2'b10, 16'h3412, 16'h127E, 16'h0012};
      vecs[3] = '{1'b0, 2'b00, 16'hFFFF, 16'h127E, 16'h127E};
      vecs[4] = '{1'b1, 2'b01, 16'hFF00, 16'h1200, 16'h0000};
      vecs[5] = '{1'b1, 2'b00, 16'h00FF, 16'h00FF, 16'h00FF};
      vecs[6] = '{1'b0, 2'b11, 16'h0000, 16'h00FF, 16'h0002};

      rst       = 1'b0;
      led_wen   = 1'b0;
      led_addr  = 2'b00;
      led_wdata = 16'h0000;
      #3;
      check("reset_led", led, 16'h0000);
      rd(2'b00, 16'h0000, "reset_rd_word");
      rd(2'b11, 16'h0002, "reset_rd_ctrl");
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         step(vecs[i].wen, vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
         check($sformatf("vec%0d_rdata", i), led_rdata, vecs[i].exp_rdata);
      end

`ifdef LED_BLINK_EN
      step(1'b1, 2'b11, 16'h0001);
      check("blink_en_led", led, 16'h00FF);
      check("blink_en_rd", led_rdata, 16'h0003);
      for (int k = 1; k <= 12; k++) begin
         logic on;
         on = ((k / 4) % 2) == 0;
         step(1'b0, 2'b11, 16'h0000);
         check($sformatf("blink_e%0d_led", k), led, on ? 16'h00FF : 16'h0000);
         check($sformatf("blink_e%0d_rd", k), led_rdata, on ? 16'h0003 : 16'h0001);
      end
      step(1'b1, 2'b11, 16'h0000);
      check("disable_led", led, 16'h00FF);
      check("disable_rd", led_rdata, 16'h0002);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 2'b11, 16'h0000);
         check($sformatf("steady%0d_led", k), led, 16'h00FF);
      end

      step(1'b1, 2'b11, 16'h0001);
      check("reenable_led", led, 16'h00FF);
      for (int k = 1; k <= 12; k++) begin
         logic        on;
         logic [15:0] d;
         on = ((k / 4) % 2) == 0;
         d  = (k >= 8) ? 16'hF00F : 16'h00FF;
         if (k == 2)      step(1'b1, 2'b11, 16'h0001);
         else if (k == 8) step(1'b1, 2'b00, 16'hF00F);
         else             step(1'b0, 2'b11, 16'h0000);
         check($sformatf("simul_e%0d_led", k), led, on ? d : 16'h0000);
      end
`else
      step(1'b1, 2'b11, 16'h0001);
      check("noblink_wr_led", led, 16'h00FF);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 2'b11, 16'h0000);
         check($sformatf("noblink_e%0d_led", k), led, 16'h00FF);
      end
      rd(2'b11, 16'h0002, "noblink_rd_ctrl");
`endif

      // Asynchronous reset in the middle of a cycle, away from any edge.
      #2;
      rst = 1'b0;
      #1;
      check("midrst_led", led, 16'h0000);
      rd(2'b00, 16'h0000, "midrst_rd_word");
      rd(2'b11, 16'h0002, "midrst_rd_ctrl");
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 2'b11, 16'h0000);
         check($sformatf("postrst%0d_led", k), led, 16'h0000);
         check($sformatf("postrst%0d_rd", k), led_rdata, 16'h0002);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
